// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the
// CPU instruction-fetch port and the data load/store port (IDLE/ACCESS/CAPTURE).
module mem_bus_arbiter #(
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      sysClk,
  input  logic                      sysRes,
  input  logic                      iReq,
  input  logic [31:0]               iAddr,
  output logic [DATA_WIDTH-1:0]     iData,
  output logic                      iAck,
  output logic                      iErr,
  input  logic                      dReq,
  input  logic                      dWe,
  input  logic [3:0]                dMask,
  input  logic [31:0]               dAddr,
  input  logic [DATA_WIDTH-1:0]     dWData,
  output logic [DATA_WIDTH-1:0]     dRData,
  output logic                      dAck,
  output logic                      dErr,
  output logic                      ramEn,
  output logic                      ramWe,
  output logic [3:0]                ramMask,
  output logic [RAM_ADDR_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0]     ramWData,
  input  logic [DATA_WIDTH-1:0]     ramRData
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE} state_t;
  typedef enum logic {G_INST, G_DATA} grant_t;

  state_t                    r_state, w_state_nxt;
  grant_t                    r_grant, w_grant_nxt;
  grant_t                    r_last,  w_last_nxt;
  logic                      r_err,   w_err_nxt;
  logic                      r_wr,    w_wr_nxt;

  logic [DATA_WIDTH-1:0]     r_iData, w_iData_nxt;
  logic                      r_iAck,  w_iAck_nxt;
  logic                      r_iErr,  w_iErr_nxt;
  logic [DATA_WIDTH-1:0]     r_dRData, w_dRData_nxt;
  logic                      r_dAck,  w_dAck_nxt;
  logic                      r_dErr,  w_dErr_nxt;
  logic                      r_ramEn, w_ramEn_nxt;
  logic                      r_ramWe, w_ramWe_nxt;
  logic [3:0]                r_ramMask, w_ramMask_nxt;
  logic [RAM_ADDR_WIDTH-1:0] r_ramAddr, w_ramAddr_nxt;
  logic [DATA_WIDTH-1:0]     r_ramWData, w_ramWData_nxt;

  logic                      w_iElig, w_dElig, w_selData, w_addrErr;
  logic [31:0]               w_selAddr;

  // A port whose ack is high this cycle is masked so it is not re-served
  // on the request it is still holding.
  assign w_iElig   = iReq & ~r_iAck;
  assign w_dElig   = dReq & ~r_dAck;
  assign w_selData = (w_iElig & w_dElig) ? (r_last == G_INST) : w_dElig;
  assign w_selAddr = w_selData ? dAddr : iAddr;
  assign w_addrErr = (|w_selAddr[31:RAM_ADDR_WIDTH+2]) | (|w_selAddr[1:0]);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last;
    w_err_nxt      = r_err;
    w_wr_nxt       = r_wr;
    w_iData_nxt    = r_iData;
    w_iAck_nxt     = 1'b0;
    w_iErr_nxt     = 1'b0;
    w_dRData_nxt   = r_dRData;
    w_dAck_nxt     = 1'b0;
    w_dErr_nxt     = 1'b0;
    w_ramEn_nxt    = r_ramEn;
    w_ramWe_nxt    = r_ramWe;
    w_ramMask_nxt  = r_ramMask;
    w_ramAddr_nxt  = r_ramAddr;
    w_ramWData_nxt = r_ramWData;

    case (r_state)
      S_IDLE: begin
        if (w_iElig | w_dElig) begin
          w_state_nxt = S_ACCESS;
          w_grant_nxt = w_selData ? G_DATA : G_INST;
          w_last_nxt  = w_selData ? G_DATA : G_INST;
          w_err_nxt   = w_addrErr;
          w_wr_nxt    = w_selData & dWe;
          if (!w_addrErr) begin
            w_ramEn_nxt   = 1'b1;
            w_ramWe_nxt   = w_selData & dWe;
            w_ramAddr_nxt = w_selAddr[RAM_ADDR_WIDTH+1:2];
            if (w_selData & dWe) begin
              w_ramMask_nxt  = dMask;
              w_ramWData_nxt = dWData;
            end
          end else begin
            w_ramEn_nxt = 1'b0;
            w_ramWe_nxt = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        w_state_nxt   = S_CAPTURE;
        w_ramEn_nxt   = 1'b0;
        w_ramWe_nxt   = 1'b0;
        w_ramMask_nxt = '0;
      end
      S_CAPTURE: begin
        w_state_nxt = S_IDLE;
        if (r_grant == G_INST) begin
          w_iAck_nxt  = 1'b1;
          w_iErr_nxt  = r_err;
          w_iData_nxt = r_err ? '0 : ramRData;
        end else begin
          w_dAck_nxt = 1'b1;
          w_dErr_nxt = r_err;
          if (!r_wr) begin
            w_dRData_nxt = r_err ? '0 : ramRData;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysRes) begin
      r_state    <= S_IDLE;
      r_grant    <= G_INST;
      r_last     <= G_DATA;
      r_err      <= 1'b0;
      r_wr       <= 1'b0;
      r_iData    <= '0;
      r_iAck     <= 1'b0;
      r_iErr     <= 1'b0;
      r_dRData   <= '0;
      r_dAck     <= 1'b0;
      r_dErr     <= 1'b0;
      r_ramEn    <= 1'b0;
      r_ramWe    <= 1'b0;
      r_ramMask  <= '0;
      r_ramAddr  <= '0;
      r_ramWData <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last     <= w_last_nxt;
      r_err      <= w_err_nxt;
      r_wr       <= w_wr_nxt;
      r_iData    <= w_iData_nxt;
      r_iAck     <= w_iAck_nxt;
      r_iErr     <= w_iErr_nxt;
      r_dRData   <= w_dRData_nxt;
      r_dAck     <= w_dAck_nxt;
      r_dErr     <= w_dErr_nxt;
      r_ramEn    <= w_ramEn_nxt;
      r_ramWe    <= w_ramWe_nxt;
      r_ramMask  <= w_ramMask_nxt;
      r_ramAddr  <= w_ramAddr_nxt;
      r_ramWData <= w_ramWData_nxt;
    end
  end

  assign iData    = r_iData;
  assign iAck     = r_iAck;
  assign iErr     = r_iErr;
  assign dRData   = r_dRData;
  assign dAck     = r_dAck;
  assign dErr     = r_dErr;
  assign ramEn    = r_ramEn;
  assign ramWe    = r_ramWe;
  assign ramMask  = r_ramMask;
  assign ramAddr  = r_ramAddr;
  assign ramWData = r_ramWData;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural byte-masked
// synchronous RAM (one-cycle registered read) attached to the RAM port.
module tb_mem_bus_arbiter;

  localparam int AW = 12;

  logic          sysClk, sysRes;
  logic          iReq, iAck, iErr;
  logic [31:0]   iAddr, iData;
  logic          dReq, dWe, dAck, dErr;
  logic [3:0]    dMask;
  logic [31:0]   dAddr, dWData, dRData;
  logic          ramEn, ramWe;
  logic [3:0]    ramMask;
  logic [AW-1:0] ramAddr;
  logic [31:0]   ramWData, ramRData;

  mem_bus_arbiter #(.RAM_ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .sysClk(sysClk), .sysRes(sysRes),
    .iReq(iReq), .iAddr(iAddr), .iData(iData), .iAck(iAck), .iErr(iErr),
    .dReq(dReq), .dWe(dWe), .dMask(dMask), .dAddr(dAddr), .dWData(dWData),
    .dRData(dRData), .dAck(dAck), .dErr(dErr),
    .ramEn(ramEn), .ramWe(ramWe), .ramMask(ramMask), .ramAddr(ramAddr),
    .ramWData(ramWData), .ramRData(ramRData)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge sysClk) begin
    if (ramEn) begin
      if (ramWe) begin
        for (int b = 0; b < 4; b++)
          if (ramMask[b]) mem[ramAddr][b*8 +: 8] <= ramWData[b*8 +: 8];
      end
      ramRData <= mem[ramAddr];
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic sawEn, sawWe, sawAck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Monitor: pops expectations whenever a port presents an ack.
  always @(negedge sysClk) begin
    exp_t ie, de;
    if (iAck) begin
      if (iq.size() == 0) fail("i_unexpected_ack");
      else begin
        ie = iq.pop_front();
        chk("i_data", iData, ie.data);
        chk("i_err", {31'd0, iErr}, {31'd0, ie.err});
      end
    end
    if (dAck) begin
      if (dq.size() == 0) fail("d_unexpected_ack");
      else begin
        de = dq.pop_front();
        chk("d_rdata", dRData, de.data);
        chk("d_err", {31'd0, dErr}, {31'd0, de.err});
      end
    end
    sawEn  = sawEn | ramEn;
    sawWe  = sawWe | ramWe;
    sawAck = sawAck | iAck | dAck;
  end

  task automatic wait_ack(input bit dport, input string nm, output int cyc);
    cyc = 0;
    do begin
      @(posedge sysClk); #1;
      cyc++;
    end while (!(dport ? dAck : iAck) && cyc < 20);
    if (!(dport ? dAck : iAck)) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: no ack after %0d cycles", nm, cyc);
    end
  endtask

  task automatic inst_rd(input string nm, input logic [31:0] a,
                         input logic [31:0] ed, input logic ee);
    exp_t e;
    int   c;
    e.data = ed; e.err = ee;
    iq.push_back(e);
    iAddr = a; iReq = 1'b1;
    wait_ack(1'b0, nm, c);
    chk({nm, "_latency"}, c, 3);
    iReq = 1'b0;
    @(posedge sysClk); #1;
  endtask

  task automatic data_acc(input string nm, input logic we, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] ed, input logic ee);
    exp_t e;
    int   c;
    e.data = ed; e.err = ee;
    dq.push_back(e);
    dWe = we; dMask = m; dAddr = a; dWData = wd; dReq = 1'b1;
    wait_ack(1'b1, nm, c);
    chk({nm, "_latency"}, c, 3);
    dReq = 1'b0;
    @(posedge sysClk); #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {24'd0, iAck, iErr, dAck, dErr, ramEn, ramWe, 2'd0} | {28'd0, ramMask}, 32'd0);
    chk({nm, "_iData"}, iData, 32'd0);
    chk({nm, "_dRData"}, dRData, 32'd0);
    chk({nm, "_ramAddr"}, {20'd0, ramAddr}, 32'd0);
    chk({nm, "_ramWData"}, ramWData, 32'd0);
  endtask

  task automatic do_reset();
    sysRes = 1'b1;
    repeat (2) @(posedge sysClk);
    #1;
    sysRes = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, prev, k, ni, nd;
    logic [3:0] ord;
    int t [0:3];
    exp_t e;

    sysRes = 1'b1; iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWe = 1'b0;
    dMask = '0; dAddr = '0; dWData = '0; ramRData = '0;
    sawEn = 1'b0; sawWe = 1'b0; sawAck = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    mem[5]  = 32'h0000_0013;
    mem[8]  = 32'h1122_3344;
    mem[16] = 32'hA0A0_0010; mem[17] = 32'hA0A0_0011;
    mem[18] = 32'hD0D0_0012; mem[19] = 32'hD0D0_0013;
    for (int i = 0; i < 4; i++) mem[20+i] = 32'h6000_0000 + 32'h111 * (i + 1);

    do_reset();
    chk_zero("reset");

    // Single fetch
    sawWe = 1'b0;
    inst_rd("t1_fetch", 32'h14, 32'h0000_0013, 1'b0);
    chk("t1_no_ramWe", {31'd0, sawWe}, 32'd0);

    // Byte write, then read back; dRData holds across writes
    data_acc("t2_write", 1'b1, 4'b0010, 32'h20, 32'h0000_AB00, 32'h0, 1'b0);
    data_acc("t2_read",  1'b0, 4'b0000, 32'h20, 32'h0, 32'h1122_AB44, 1'b0);
    data_acc("mask0_write", 1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 32'h1122_AB44, 1'b0);
    data_acc("mask0_read",  1'b0, 4'b0000, 32'h20, 32'h0, 32'h1122_AB44, 1'b0);
    data_acc("top_write", 1'b1, 4'b1111, 32'h3FFC, 32'h5A5A_A5A5, 32'h1122_AB44, 1'b0);
    data_acc("top_read",  1'b0, 4'b0000, 32'h3FFC, 32'h0, 32'h5A5A_A5A5, 1'b0);

    // Address errors: no RAM activity, same latency
    sawEn = 1'b0;
    inst_rd("t4_inst_oor", 32'h0000_4000, 32'h0, 1'b1);
    chk("t4_inst_no_ramEn", {31'd0, sawEn}, 32'd0);
    sawEn = 1'b0;
    data_acc("t4_wr_oor", 1'b1, 4'b1111, 32'hFFFF_0000, 32'h1234_5678, 32'h5A5A_A5A5, 1'b1);
    chk("t4_wr_no_ramEn", {31'd0, sawEn}, 32'd0);
    sawEn = 1'b0;
    data_acc("t4_rd_misalign", 1'b0, 4'b0000, 32'h22, 32'h0, 32'h0, 1'b1);
    chk("t4_rd_no_ramEn", {31'd0, sawEn}, 32'd0);

    // Back-to-back fetches on one port with req held high
    for (int i = 0; i < 4; i++) begin
      e.data = mem[20+i]; e.err = 1'b0;
      iq.push_back(e);
    end
    iAddr = 32'h50; iReq = 1'b1; cyc = 0; prev = 0; k = 0;
    while (k < 4 && cyc < 40) begin
      @(posedge sysClk); #1;
      cyc++;
      if (iAck) begin
        if (k == 0) chk("t6_first_latency", cyc, 3);
        else        chk("t6_ack_spacing", cyc - prev, 4);
        prev = cyc;
        k++;
        if (k < 4) iAddr = 32'h50 + 32'(4 * k);
        else       iReq = 1'b0;
      end
    end
    if (k < 4) begin
      n_vec++; n_bad++;
      $display("FAIL t6_timeout: got %0d acks, expected 4", k);
    end
    iReq = 1'b0;
    @(posedge sysClk); #1;

    // Contention from reset release: I first (lastGrant=DATA), then alternate
    do_reset();
    e.err = 1'b0;
    e.data = mem[16]; iq.push_back(e);
    e.data = mem[17]; iq.push_back(e);
    e.data = mem[18]; dq.push_back(e);
    e.data = mem[19]; dq.push_back(e);
    iAddr = 32'h40; dAddr = 32'h48; dWe = 1'b0; dMask = '0;
    iReq = 1'b1; dReq = 1'b1;
    cyc = 0; k = 0; ni = 0; nd = 0; ord = '0;
    while (k < 4 && cyc < 40) begin
      @(posedge sysClk); #1;
      cyc++;
      if (iAck && dAck) fail("t3_double_ack");
      else if (iAck || dAck) begin
        ord[k] = dAck;
        t[k] = cyc;
        k++;
        if (iAck) begin
          ni++;
          if (ni < 2) iAddr = 32'h44; else iReq = 1'b0;
        end else begin
          nd++;
          if (nd < 2) dAddr = 32'h4C; else dReq = 1'b0;
        end
      end
    end
    if (k < 4) begin
      n_vec++; n_bad++;
      $display("FAIL t3_timeout: got %0d acks, expected 4", k);
    end else begin
      chk("t3_order", {28'd0, ord}, 32'b1010);
      chk("t3_first_latency", t[0], 3);
      for (int i = 1; i < 4; i++) chk("t3_ack_spacing", t[i] - t[i-1], 3);
    end
    iReq = 1'b0; dReq = 1'b0;
    @(posedge sysClk); #1;

    // Reset while a write is in ACCESS: RAM still written, no ack issued
    dWe = 1'b1; dMask = 4'b1111; dAddr = 32'h30; dWData = 32'hCAFE_F00D; dReq = 1'b1;
    @(posedge sysClk); #1;
    chk("t5_write_presented", {30'd0, ramEn, ramWe}, 32'd3);
    sysRes = 1'b1; dReq = 1'b0;
    @(posedge sysClk); #1;
    chk_zero("t5_after_reset");
    sysRes = 1'b0;
    chk("t5_ram12_written", mem[12], 32'hCAFE_F00D);
    sawAck = 1'b0;
    repeat (5) @(posedge sysClk);
    #1;
    chk("t5_no_ack", {31'd0, sawAck}, 32'd0);
    data_acc("t5_read_after", 1'b0, 4'b0000, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0);

    repeat (4) @(posedge sysClk);
    #1;
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
